// File: rtl/nco_freq_bank_pkg.sv
// -----------------------------------------------------------------------------
// nco_freq_bank_pkg
// Shared address-map helpers and CTRL bit positions for the NCO frequency bank.
// The register map scales with the channel count, so the offsets are functions
// of NUM_CH rather than fixed constants.
// -----------------------------------------------------------------------------
package nco_freq_bank_pkg;

   // CTRL register bit positions
   localparam int CTRL_COMMIT   = 0;
   localparam int CTRL_RAMP_EN  = 1;
   localparam int CTRL_ANY_BUSY = 2;

   function automatic int shadow_base();
      return 0;
   endfunction

   function automatic int active_base(input int num_ch);
      return num_ch;
   endfunction

   function automatic int ctrl_ofs(input int num_ch);
      return 2 * num_ch;
   endfunction

   function automatic int step_ofs(input int num_ch);
      return 2 * num_ch + 1;
   endfunction

   function automatic int busy_ofs(input int num_ch);
      return 2 * num_ch + 2;
   endfunction

endpackage

// File: rtl/nco_ramp_lane.sv
// -----------------------------------------------------------------------------
// nco_ramp_lane
// One channel of the frequency bank: holds the ACTIVE and TARGET tuning words,
// performs the clamped linear step toward TARGET and registers the busy flag.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   commit      : load TARGET from shadow this cycle
//   jump        : with commit, also load ACTIVE from shadow (no ramp)
//   step_en     : take one ramp step this cycle (already excludes commit)
//   shadow      : shadow FTW for this channel
//   step        : ramp step size
//   active      : current active FTW
//   busy        : registered (active != target)
//   change      : combinational, ACTIVE takes a new value at the next edge
// -----------------------------------------------------------------------------
module nco_ramp_lane
   import nco_freq_bank_pkg::*;
#(
   parameter int FTW_W  = 20,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              commit,
   input  logic              jump,
   input  logic              step_en,
   input  logic [FTW_W-1:0]  shadow,
   input  logic [STEP_W-1:0] step,
   output logic [FTW_W-1:0]  active,
   output logic              busy,
   output logic              change
);

   logic [FTW_W-1:0] target;
   logic [FTW_W-1:0] active_nxt;
   logic [FTW_W-1:0] target_nxt;

   // One step toward t, clamped so it never passes t. The extra guard bit
   // keeps the intermediate sum/difference free of wrap-around.
   function automatic logic [FTW_W-1:0] clamp_step(
      input logic [FTW_W-1:0]  a,
      input logic [FTW_W-1:0]  t,
      input logic [STEP_W-1:0] s
   );
      logic [FTW_W:0] a_g;
      logic [FTW_W:0] t_g;
      logic [FTW_W:0] s_g;
      logic [FTW_W:0] diff;
      logic [FTW_W:0] res;
      a_g = {1'b0, a};
      t_g = {1'b0, t};
      s_g = (FTW_W+1)'(s);
      if (t_g >= a_g) begin
         diff = t_g - a_g;
         res  = (diff <= s_g) ? t_g : (a_g + s_g);
      end else begin
         diff = a_g - t_g;
         res  = (diff <= s_g) ? t_g : (a_g - s_g);
      end
      return FTW_W'(res);
   endfunction

   always_comb begin
      active_nxt = active;
      target_nxt = target;
      if (commit) begin
         target_nxt = shadow;
         if (jump) begin
            active_nxt = shadow;
         end
      end else if (step_en) begin
         active_nxt = clamp_step(active, target, step);
      end
   end

   assign change = (active_nxt != active);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active <= '0;
         target <= '0;
         busy   <= 1'b0;
      end else begin
         active <= active_nxt;
         target <= target_nxt;
         // Compare the next-state values so busy lines up with ACTIVE.
         busy   <= (active_nxt != target_nxt);
      end
   end

endmodule

// File: rtl/nco_freq_bank.sv
// -----------------------------------------------------------------------------
// nco_freq_bank
// Multi-channel NCO frequency-control register bank on an Avalon-MM slave.
// Shadow FTWs are written over the bus; a CTRL commit moves all of them to the
// active set at once, either as an immediate jump or as a linear glide of STEP
// per tick (one tick every TICK_DIV clocks).
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   address     : word address
//   chipselect  : slave select
//   write_n     : active-low write strobe
//   writedata   : write data
//   readdata    : combinational read data (zero wait, zero latency)
//   ftw_out     : active FTWs, channel i at [i*FTW_W +: FTW_W]
//   ftw_upd     : one-cycle pulse when any active FTW took a new value
//   busy        : per-channel ramp in progress
// -----------------------------------------------------------------------------
module nco_freq_bank
   import nco_freq_bank_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int FTW_W    = 20,
   parameter int STEP_W   = 16,
   parameter int TICK_DIV = 1000,
   parameter int ADDR_W   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       address,
   input  logic                    chipselect,
   input  logic                    write_n,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   output logic [NUM_CH*FTW_W-1:0] ftw_out,
   output logic                    ftw_upd,
   output logic [NUM_CH-1:0]       busy
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(ctrl_ofs(NUM_CH));
   localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(step_ofs(NUM_CH));
   localparam logic [ADDR_W-1:0] A_BUSY = ADDR_W'(busy_ofs(NUM_CH));
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic              wr;
   logic              commit;
   logic              jump;
   logic              tick;
   logic              step_en;
   logic              ramp_en;
   logic [STEP_W-1:0] step;
   logic [CNT_W-1:0]  cnt;
   logic [FTW_W-1:0]  shadow [NUM_CH];
   logic [FTW_W-1:0]  active [NUM_CH];
   logic [NUM_CH-1:0] busy_ch;
   logic [NUM_CH-1:0] change;
   logic              unused_wd;

   // Only the low FTW_W/STEP_W/CTRL bits of writedata are meaningful.
   assign unused_wd = ^writedata;

   assign wr     = chipselect & ~write_n;
   assign commit = wr && (address == A_CTRL) && writedata[CTRL_COMMIT];
   // The RAMP_EN value being written alongside the commit decides the mode.
   assign jump   = ~writedata[CTRL_RAMP_EN] || (step == '0);
   assign tick   = (cnt == CNT_MAX);
   // A commit in the same cycle as a tick wins; no step is taken.
   assign step_en = tick & ramp_en & ~commit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= '0;
         end
         step    <= '0;
         ramp_en <= 1'b0;
         cnt     <= '0;
         ftw_upd <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr && (address == ADDR_W'(shadow_base() + i))) begin
               shadow[i] <= writedata[FTW_W-1:0];
            end
         end
         if (wr && (address == A_STEP)) begin
            step <= writedata[STEP_W-1:0];
         end
         if (wr && (address == A_CTRL)) begin
            ramp_en <= writedata[CTRL_RAMP_EN];
         end
         // Restarting on commit makes the first step land exactly TICK_DIV
         // clocks after the commit edge.
         if (commit || tick) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         ftw_upd <= |change;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      nco_ramp_lane #(
         .FTW_W  (FTW_W),
         .STEP_W (STEP_W)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .commit  (commit),
         .jump    (jump),
         .step_en (step_en),
         .shadow  (shadow[g]),
         .step    (step),
         .active  (active[g]),
         .busy    (busy_ch[g]),
         .change  (change[g])
      );
      assign ftw_out[g*FTW_W +: FTW_W] = active[g];
   end

   assign busy = busy_ch;

   always_comb begin
      readdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (address == ADDR_W'(shadow_base() + i)) begin
            readdata = 32'(shadow[i]);
         end
         if (address == ADDR_W'(active_base(NUM_CH) + i)) begin
            readdata = 32'(active[i]);
         end
      end
      if (address == A_CTRL) begin
         readdata[CTRL_RAMP_EN]  = ramp_en;
         readdata[CTRL_ANY_BUSY] = |busy_ch;
      end
      if (address == A_STEP) begin
         readdata = 32'(step);
      end
      if (address == A_BUSY) begin
         readdata = 32'(busy_ch);
      end
   end

endmodule

// File: tb/tb_nco_freq_bank.sv
// -----------------------------------------------------------------------------
// tb_nco_freq_bank
// Self-checking bench for nco_freq_bank (NUM_CH=4, FTW_W=20, TICK_DIV=4).
// Expected values are queued when stimulus is applied and compared in order
// when the corresponding DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_nco_freq_bank;

   localparam int NUM_CH   = 4;
   localparam int FTW_W    = 20;
   localparam int STEP_W   = 16;
   localparam int TICK_DIV = 4;
   localparam int ADDR_W   = 4;
   localparam int A_CTRL   = 8;
   localparam int A_STEP   = 9;
   localparam int A_BUSY   = 10;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [ADDR_W-1:0]       address;
   logic                    chipselect;
   logic                    write_n;
   logic [31:0]             writedata;
   logic [31:0]             readdata;
   logic [NUM_CH*FTW_W-1:0] ftw_out;
   logic                    ftw_upd;
   logic [NUM_CH-1:0]       busy;

   nco_freq_bank #(
      .NUM_CH   (NUM_CH),
      .FTW_W    (FTW_W),
      .STEP_W   (STEP_W),
      .TICK_DIV (TICK_DIV),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .ftw_out    (ftw_out),
      .ftw_upd    (ftw_upd),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   string       tag_q[$];
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] exp);
      tag_q.push_back(tag);
      exp_q.push_back(exp);
   endtask

   task automatic sb_pop(input logic [31:0] obs);
      if (tag_q.size() == 0) begin
         chk("sb_underflow", 32'(tag_q.size()), 32'd1);
      end else begin
         chk(tag_q.pop_front(), obs, exp_q.pop_front());
      end
   endtask

   function automatic logic [31:0] ch(input int i);
      return 32'(ftw_out[i*FTW_W +: FTW_W]);
   endfunction

   task automatic bus_write(input int a, input logic [31:0] d);
      @(negedge clk);
      address    = ADDR_W'(a);
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input int a, output logic [31:0] d);
      @(negedge clk);
      address    = ADDR_W'(a);
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      d          = readdata;
      chipselect = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        found;

      reset      = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state: every address reads 0, all outputs 0
      for (int a = 0; a < 16; a++) sb_push($sformatf("rd_reset_a%0d", a), 32'd0);
      for (int a = 0; a < 16; a++) begin
         bus_read(a, rd);
         sb_pop(rd);
      end
      sb_push("rst_ftw_nonzero", 32'd0);
      sb_push("rst_busy", 32'd0);
      sb_push("rst_upd", 32'd0);
      sb_pop(32'(ftw_out != '0));
      sb_pop(32'(busy));
      sb_pop(32'(ftw_upd));

      // Immediate jump commit
      bus_write(0, 32'h12345);
      bus_write(3, 32'hFFFFF);
      sb_push("shadow_no_effect", 32'd0);
      sb_pop(ch(0));
      sb_push("jump_ch0", 32'h12345);
      sb_push("jump_ch3", 32'hFFFFF);
      sb_push("jump_ch1", 32'h0);
      sb_push("jump_upd_hi", 32'd1);
      sb_push("jump_busy", 32'd0);
      bus_write(A_CTRL, 32'h1);
      sb_pop(ch(0));
      sb_pop(ch(3));
      sb_pop(ch(1));
      sb_pop(32'(ftw_upd));
      sb_pop(32'(busy));
      sb_push("jump_upd_lo", 32'd0);
      @(posedge clk); #1;
      sb_pop(32'(ftw_upd));
      sb_push("rd_active0", 32'h12345);
      sb_push("rd_active3", 32'hFFFFF);
      sb_push("rd_shadow3", 32'hFFFFF);
      bus_read(4, rd); sb_pop(rd);
      bus_read(7, rd); sb_pop(rd);
      bus_read(3, rd); sb_pop(rd);

      // Up-ramp 0 -> 0x350, step 0x100
      @(negedge clk); reset = 1'b1; #2; reset = 1'b0;
      bus_write(A_STEP, 32'h100);
      bus_write(A_CTRL, 32'h2);
      bus_write(0, 32'h350);
      sb_push("up_commit_nojump", 32'h0);
      sb_push("up_commit_busy", 32'h1);
      sb_push("up_c3", 32'h0);
      sb_push("up_c4", 32'h100);
      sb_push("up_c4_upd", 32'd1);
      sb_push("up_c5_upd", 32'd0);
      sb_push("up_c8", 32'h200);
      sb_push("up_c12", 32'h300);
      sb_push("up_c15_busy", 32'd1);
      sb_push("up_c16", 32'h350);
      sb_push("up_c16_busy", 32'd0);
      bus_write(A_CTRL, 32'h3);
      sb_pop(ch(0));
      sb_pop(32'(busy[0]));
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk); #1;
         case (c)
            3:  sb_pop(ch(0));
            4:  begin sb_pop(ch(0)); sb_pop(32'(ftw_upd)); end
            5:  sb_pop(32'(ftw_upd));
            8:  sb_pop(ch(0));
            12: sb_pop(ch(0));
            15: sb_pop(32'(busy[0]));
            16: begin sb_pop(ch(0)); sb_pop(32'(busy[0])); end
            default: ;
         endcase
      end

      // Down-ramp 0x350 -> 0, step 0x200, clamped at zero
      bus_write(A_STEP, 32'h200);
      bus_write(0, 32'h0);
      sb_push("dn_c4", 32'h150);
      sb_push("dn_c7_busy", 32'd1);
      sb_push("dn_c8", 32'h0);
      sb_push("dn_c8_busy", 32'd0);
      bus_write(A_CTRL, 32'h3);
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         case (c)
            4: sb_pop(ch(0));
            7: sb_pop(32'(busy[0]));
            8: begin sb_pop(ch(0)); sb_pop(32'(busy[0])); end
            default: ;
         endcase
      end

      // Mid-ramp pause, resume and retarget
      bus_write(A_STEP, 32'h100);
      bus_write(0, 32'h1000);
      sb_push("mid_c4", 32'h100);
      sb_push("mid_c8", 32'h200);
      bus_write(A_CTRL, 32'h3);
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (c == 4 || c == 8) sb_pop(ch(0));
      end
      bus_write(A_CTRL, 32'h0);
      repeat (8) @(posedge clk);
      sb_push("frozen_ch0", 32'h200);
      sb_push("frozen_busy", 32'd1);
      sb_push("frozen_rd_ctrl", 32'h4);
      sb_push("frozen_rd_busy", 32'h1);
      #1;
      sb_pop(ch(0));
      sb_pop(32'(busy[0]));
      bus_read(A_CTRL, rd); sb_pop(rd);
      bus_read(A_BUSY, rd); sb_pop(rd);
      bus_write(A_CTRL, 32'h2);
      found = 1'b0;
      for (int n = 0; n < 8 && !found; n++) begin
         @(posedge clk); #1;
         if (ch(0) != 32'h200) found = 1'b1;
      end
      chk("resume_seen", 32'(found), 32'd1);
      sb_push("resume_ch0", 32'h300);
      sb_pop(ch(0));
      bus_write(0, 32'h250);
      sb_push("retarget_nojump", 32'h300);
      sb_push("retarget_busy", 32'd1);
      bus_write(A_CTRL, 32'h3);
      sb_pop(ch(0));
      sb_pop(32'(busy[0]));
      sb_push("retarget_c4", 32'h250);
      sb_push("retarget_c4_busy", 32'd0);
      repeat (4) @(posedge clk);
      #1;
      sb_pop(ch(0));
      sb_pop(32'(busy[0]));

      // STEP=0 in ramp mode jumps immediately
      bus_write(A_STEP, 32'h0);
      bus_write(1, 32'h777);
      sb_push("step0_jump_ch1", 32'h777);
      sb_push("step0_upd", 32'd1);
      bus_write(A_CTRL, 32'h3);
      sb_pop(ch(1));
      sb_pop(32'(ftw_upd));

      // Asynchronous reset during a ramp
      bus_write(A_STEP, 32'h10);
      bus_write(1, 32'h0);
      bus_write(A_CTRL, 32'h3);
      sb_push("pre_reset_ch1", 32'h767);
      sb_push("pre_reset_busy", 32'h2);
      repeat (6) @(posedge clk);
      #1;
      sb_pop(ch(1));
      sb_pop(32'(busy));
      sb_push("async_rst_ftw_nonzero", 32'd0);
      sb_push("async_rst_busy", 32'd0);
      sb_push("async_rst_upd", 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      sb_pop(32'(ftw_out != '0));
      sb_pop(32'(busy));
      sb_pop(32'(ftw_upd));
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      sb_push("post_rst_ctrl", 32'd0);
      sb_push("post_rst_step", 32'd0);
      bus_read(A_CTRL, rd); sb_pop(rd);
      bus_read(A_STEP, rd); sb_pop(rd);

      chk("sb_drained", 32'(tag_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
